// File: rtl/invader_fleet.sv
// Six-invader fleet: marches on frame ticks, answers laser hits with a one-clk
// collision pulse, signals landing, and respawns a cleared wave after a delay.
module invader_fleet #(
  parameter int unsigned X_START        = 64,
  parameter int unsigned Y_START        = 48,
  parameter int unsigned INV_W          = 32,
  parameter int unsigned INV_H          = 16,
  parameter int unsigned PITCH          = 64,
  parameter int unsigned STEP_X         = 4,
  parameter int unsigned DROP_Y         = 16,
  parameter int unsigned X_MIN          = 8,
  parameter int unsigned X_MAX          = 280,
  parameter int unsigned LAND_Y         = 440,
  parameter int unsigned MOVE_FRAMES    = 4,
  parameter int unsigned RESPAWN_FRAMES = 60
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_arst,
  input  logic       i_frame,
  input  logic       i_laser_active,
  input  logic [9:0] i_laser_x,
  input  logic [9:0] i_laser_y,
  output logic [9:0] o_invaders_x,
  output logic [9:0] o_invaders_y,
  output logic [5:0] o_invader_alive,
  output logic [5:0] o_invader_collision,
  output logic       o_player_collision
);

  localparam int unsigned N_INV = 6;
  localparam int unsigned POS_W = 10;
  localparam int unsigned GEO_W = 11;
  localparam int unsigned CNT_W = 6;

  typedef enum logic {PLAY, RESPAWN} state_t;
  typedef enum logic {RIGHT, LEFT} dir_t;

  state_t             r_state, w_state_n;
  dir_t               r_dir, w_dir_n;
  logic [CNT_W-1:0]   r_frame_cnt, w_frame_cnt_n;
  logic [POS_W-1:0]   r_x, w_x_n;
  logic [POS_W-1:0]   r_y, w_y_n;
  logic [N_INV-1:0]   r_alive, w_alive_n;
  logic [N_INV-1:0]   r_inv_coll, w_inv_coll_n;
  logic               r_player_coll, w_player_coll_n;

  logic [GEO_W-1:0]   w_lx, w_ly, w_fx, w_fy;
  logic [N_INV-1:0]   w_hit;
  logic               w_at_edge, w_land;

  assign w_lx = {1'b0, i_laser_x};
  assign w_ly = {1'b0, i_laser_y};
  assign w_fx = {1'b0, r_x};
  assign w_fy = {1'b0, r_y};

  // Edge test compares before stepping so the left bound never underflows.
  assign w_at_edge = (r_dir == RIGHT) ? ((w_fx + GEO_W'(STEP_X)) > GEO_W'(X_MAX))
                                      : (w_fx < GEO_W'(X_MIN + STEP_X));
  assign w_land    = (w_fy + GEO_W'(DROP_Y)) >= GEO_W'(LAND_Y);

  // Per-invader box test on the registered (pre-move) position.
  always_comb begin
    logic [GEO_W-1:0] box_l;
    logic             in_y;
    w_hit = '0;
    box_l = '0;
    in_y  = (w_ly >= w_fy) && (w_ly <= (w_fy + GEO_W'(INV_H - 1)));
    for (int i = 0; i < int'(N_INV); i++) begin
      box_l    = w_fx + GEO_W'(PITCH * i);
      w_hit[i] = i_laser_active & r_alive[i] & in_y &
                 (w_lx >= box_l) & (w_lx <= (box_l + GEO_W'(INV_W - 1)));
    end
  end

  always_comb begin
    w_state_n       = r_state;
    w_dir_n         = r_dir;
    w_frame_cnt_n   = r_frame_cnt;
    w_x_n           = r_x;
    w_y_n           = r_y;
    w_alive_n       = r_alive;
    w_inv_coll_n    = '0;
    w_player_coll_n = 1'b0;

    if (i_arst) begin
      w_state_n     = PLAY;
      w_dir_n       = RIGHT;
      w_frame_cnt_n = '0;
      w_x_n         = POS_W'(X_START);
      w_y_n         = POS_W'(Y_START);
      w_alive_n     = '1;
    end else begin
      case (r_state)
        PLAY: begin
          w_alive_n    = r_alive & ~w_hit;
          w_inv_coll_n = w_hit;
          if (i_frame) begin
            if (r_frame_cnt == CNT_W'(MOVE_FRAMES - 1)) begin
              w_frame_cnt_n = '0;
              if (!w_at_edge) begin
                w_x_n = (r_dir == RIGHT) ? (r_x + POS_W'(STEP_X)) : (r_x - POS_W'(STEP_X));
              end else if (w_land) begin
                w_player_coll_n = 1'b1;
                w_x_n           = POS_W'(X_START);
                w_y_n           = POS_W'(Y_START);
                w_dir_n         = RIGHT;
              end else begin
                w_y_n   = r_y + POS_W'(DROP_Y);
                w_dir_n = (r_dir == RIGHT) ? LEFT : RIGHT;
              end
            end else begin
              w_frame_cnt_n = r_frame_cnt + CNT_W'(1);
            end
          end
          // Last kill commits with any move on this edge; RESPAWN counts from zero.
          if (w_alive_n == '0) begin
            w_state_n     = RESPAWN;
            w_frame_cnt_n = '0;
          end
        end
        RESPAWN: begin
          if (i_frame) begin
            if (r_frame_cnt == CNT_W'(RESPAWN_FRAMES - 1)) begin
              w_state_n     = PLAY;
              w_dir_n       = RIGHT;
              w_frame_cnt_n = '0;
              w_x_n         = POS_W'(X_START);
              w_y_n         = POS_W'(Y_START);
              w_alive_n     = '1;
            end else begin
              w_frame_cnt_n = r_frame_cnt + CNT_W'(1);
            end
          end
        end
        default: w_state_n = PLAY;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= PLAY;
      r_dir         <= RIGHT;
      r_frame_cnt   <= '0;
      r_x           <= POS_W'(X_START);
      r_y           <= POS_W'(Y_START);
      r_alive       <= '1;
      r_inv_coll    <= '0;
      r_player_coll <= 1'b0;
    end else begin
      r_state       <= w_state_n;
      r_dir         <= w_dir_n;
      r_frame_cnt   <= w_frame_cnt_n;
      r_x           <= w_x_n;
      r_y           <= w_y_n;
      r_alive       <= w_alive_n;
      r_inv_coll    <= w_inv_coll_n;
      r_player_coll <= w_player_coll_n;
    end
  end

  assign o_invaders_x        = r_x;
  assign o_invaders_y        = r_y;
  assign o_invader_alive     = r_alive;
  assign o_invader_collision = r_inv_coll;
  assign o_player_collision  = r_player_coll;

endmodule

// File: tb/tb_invader_fleet.sv
// Bench for invader_fleet: directed scenarios plus random play, every cycle
// checked against a pixel-level behavioural model of the fleet.
module tb_invader_fleet;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       arst = 1'b0;
  logic       frame = 1'b0;
  logic       la = 1'b0;
  logic [9:0] lx = '0;
  logic [9:0] ly = '0;
  logic [9:0] ox, oy;
  logic [5:0] oalive, ocoll;
  logic       opc;

  always #5 clk = ~clk;

  invader_fleet dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_arst              (arst),
    .i_frame             (frame),
    .i_laser_active      (la),
    .i_laser_x           (lx),
    .i_laser_y           (ly),
    .o_invaders_x        (ox),
    .o_invaders_y        (oy),
    .o_invader_alive     (oalive),
    .o_invader_collision (ocoll),
    .o_player_collision  (opc)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  // Model state in plain integers.
  int         mx = 64, my = 48, mcnt = 0;
  bit         mright = 1'b1, mresp = 1'b0, mpc = 1'b0;
  logic [5:0] malive = 6'h3f, mcoll = 6'h00;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: find the struck invader by dividing the laser offset by the pitch.
  always @(posedge clk) begin : model
    int         off, idx;
    logic [5:0] hits;
    if (rst || arst) begin
      mx = 64; my = 48; mcnt = 0; mright = 1'b1; mresp = 1'b0;
      malive = 6'h3f; mcoll = 6'h00; mpc = 1'b0;
    end else if (!mresp) begin
      hits = 6'h00;
      mpc  = 1'b0;
      if (la && int'(ly) >= my && int'(ly) < my + 16 && int'(lx) >= mx) begin
        off = int'(lx) - mx;
        idx = off / 64;
        if (idx < 6 && (off % 64) < 32 && malive[idx]) hits[idx] = 1'b1;
      end
      mcoll  = hits;
      malive = malive & ~hits;
      if (frame) begin
        if (mcnt == 3) begin
          mcnt = 0;
          if (mright && mx + 4 <= 280)      mx = mx + 4;
          else if (!mright && mx - 4 >= 8)  mx = mx - 4;
          else if (my + 16 >= 440) begin
            mpc = 1'b1; mx = 64; my = 48; mright = 1'b1;
          end else begin
            my = my + 16; mright = !mright;
          end
        end else begin
          mcnt = mcnt + 1;
        end
      end
      if (malive == 6'h00) begin
        mresp = 1'b1; mcnt = 0;
      end
    end else begin
      mcoll = 6'h00;
      mpc   = 1'b0;
      if (frame) begin
        if (mcnt == 59) begin
          mresp = 1'b0; mcnt = 0; mx = 64; my = 48; mright = 1'b1; malive = 6'h3f;
        end else begin
          mcnt = mcnt + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_x", int'(ox), mx);
      chk("model_y", int'(oy), my);
      chk("model_alive", int'(oalive), int'(malive));
      chk("model_icoll", int'(ocoll), int'(mcoll));
      chk("model_pcoll", int'(opc), int'(mpc));
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic pulse();
    frame = 1'b1; cyc();
    frame = 1'b0; cyc();
  endtask

  task automatic tick();
    repeat (4) pulse();
  endtask

  task automatic shoot(input int x, input int y);
    la = 1'b1; lx = 10'(x); ly = 10'(y); cyc();
  endtask

  task automatic pos(input string nm, input int x, input int y);
    chk({nm, "_x"}, int'(ox), x);
    chk({nm, "_y"}, int'(oy), y);
  endtask

  initial begin
    int  land_frames;
    bit  seen;

    repeat (2) cyc();
    pos("reset", 64, 48);
    chk("reset_alive", int'(oalive), 63);
    chk("reset_icoll", int'(ocoll), 0);
    chk("reset_pcoll", int'(opc), 0);
    cmp_en = 1'b1;
    rst = 1'b0;
    cyc();

    // March and right-edge drop.
    repeat (3) pulse();
    pos("march3", 64, 48);
    pulse();
    pos("march4", 68, 48);
    repeat (53) tick();
    pos("at_edge", 280, 48);
    tick();
    pos("drop", 280, 64);
    tick();
    pos("left", 276, 64);

    // Mid-march restart with a partly counted frame_cnt.
    repeat (2) pulse();
    arst = 1'b1; cyc(); arst = 1'b0;
    pos("arst", 64, 48);
    chk("arst_alive", int'(oalive), 63);

    // Single hit on invader 2, laser held in place.
    shoot(64 + 128 + 5, 50);
    chk("hit_icoll", int'(ocoll), 6'b000100);
    chk("hit_alive", int'(oalive), 6'b111011);
    cyc();
    chk("hold_icoll", int'(ocoll), 0);
    cyc();
    chk("hold2_icoll", int'(ocoll), 0);
    la = 1'b0;

    // Three pulses after arst must not move; the fourth coincides with a hit.
    repeat (3) pulse();
    pos("cnt_rst", 64, 48);
    frame = 1'b1;
    shoot(64 + 192 + 10, 48 + 15);
    frame = 1'b0; la = 1'b0;
    chk("sim_icoll", int'(ocoll), 6'b001000);
    chk("sim_alive", int'(oalive), 6'b110011);
    pos("sim", 68, 48);

    // Box boundaries at fleet (68,48), then clear the wave.
    shoot(68 + 32, 50);
    chk("gap_icoll", int'(ocoll), 0);
    shoot(68, 64);
    chk("below_icoll", int'(ocoll), 0);
    shoot(68, 48);
    chk("left_edge_icoll", int'(ocoll), 6'b000001);
    shoot(132 + 31, 63);
    chk("right_edge_icoll", int'(ocoll), 6'b000010);
    shoot(68 + 256 + 16, 55);
    chk("inv4_icoll", int'(ocoll), 6'b010000);
    shoot(68 + 320, 52);
    chk("inv5_icoll", int'(ocoll), 6'b100000);
    chk("clear_alive", int'(oalive), 0);
    shoot(80, 50);
    cyc();
    chk("resp_icoll", int'(ocoll), 0);
    la = 1'b0;
    repeat (59) pulse();
    chk("resp59_alive", int'(oalive), 0);
    pos("resp59", 68, 48);
    pulse();
    chk("resp60_alive", int'(oalive), 63);
    pos("resp60", 64, 48);

    // Full descent to landing with one invader missing.
    arst = 1'b1; cyc(); arst = 1'b0;
    shoot(64 + 320 + 1, 55); la = 1'b0;
    chk("land_pre_alive", int'(oalive), 6'b011111);
    seen = 1'b0;
    land_frames = 0;
    for (int f = 0; f < 8000 && !seen; f++) begin
      frame = 1'b1; cyc();
      if (opc) begin
        seen = 1'b1;
        land_frames = f + 1;
        pos("landed", 64, 48);
        chk("landed_alive", int'(oalive), 6'b011111);
      end
      frame = 1'b0; cyc();
    end
    chk("land_seen", int'(seen), 1);
    chk("land_ticks", land_frames, 4 * 1711);
    chk("land_pulse_len", int'(opc), 0);

    // Random play.
    for (int c = 0; c < 6000; c++) begin
      frame = ($urandom_range(0, 2) == 0);
      arst  = ($urandom_range(0, 799) == 0);
      if ($urandom_range(0, 3) == 0) begin
        la = 1'($urandom_range(0, 1));
        lx = 10'($urandom_range(0, 639));
        ly = 10'(int'(oy) + int'($urandom_range(0, 23)) - 4);
      end
      cyc();
    end
    frame = 1'b0; la = 1'b0; arst = 1'b0;
    repeat (2) cyc();
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/invader_fleet.md
# invader_fleet

Owns the six-invader fleet: position, march pattern and alive mask. It is the responder for the laser: it consumes laser_active, laser_x and laser_y from the laser block and returns the one-cycle invader_collision pulse that the laser and score_logic act on. It also raises player_collision when the fleet reaches the player row. It runs on the system clk and uses the vga_controller frame pulse as its movement time base.

## Interface
- X_START, 64: reset/respawn fleet_x, the left edge of invader 0.
- Y_START, 48: reset/respawn fleet_y, the top edge of the row.
- INV_W, 32: invader width in pixels.
- INV_H, 16: invader height in pixels.
- PITCH, 64: x distance between invader left edges.
- STEP_X, 4: horizontal step per move tick.
- DROP_Y, 16: vertical drop at an edge.
- X_MIN, 8: leftmost legal fleet_x.
- X_MAX, 280: rightmost legal fleet_x, so the right edge is at most 632.
- LAND_Y, 440: fleet_y at or beyond this counts as landing.
- MOVE_FRAMES, 4: frames per move tick.
- RESPAWN_FRAMES, 60: frames between wave clear and respawn.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- arst  in  1  debounced game restart; synchronous, single-cycle-or-longer level.
- frame  in  1  one-clk pulse per video frame, synchronous to clk.
- laser_active  in  1  laser is in flight.
- laser_x  in  10  laser tip x.
- laser_y  in  10  laser tip y.
- invaders_x  out  10  fleet_x.
- invaders_y  out  10  fleet_y.
- invader_alive  out  6  bit i is 1 while invader i is alive.
- invader_collision  out  6  one-clk pulse; bit i means invader i was hit.
- player_collision  out  1  one-clk pulse when the fleet lands.

## Operation
- Geometry: invader i occupies x from fleet_x+PITCH*i to +INV_W-1, and y from fleet_y to fleet_y+INV_H-1.
- All geometry arithmetic is 11-bit unsigned, so it cannot overflow.
- States: PLAY and RESPAWN. Direction register dir is RIGHT or LEFT. frame_cnt counts 0 to MOVE_FRAMES-1 and is reused for RESPAWN_FRAMES.
- Hit rule (PLAY only), evaluated every clk on the registered position:
  - hit_i = laser_active & alive[i] & laser inside box i.
  - On hit, the same edge registers invader_collision[i]=1 and clears alive[i].
  - Boxes never overlap, so at most one bit is set.
  - The pulse lasts exactly one clk because alive[i] is already 0 on the next cycle.
- Move tick: in PLAY, a frame pulse with frame_cnt==MOVE_FRAMES-1 moves the fleet; frame_cnt then wraps to 0. Other frame pulses only increment frame_cnt.
- Moving RIGHT:
  - If fleet_x+STEP_X <= X_MAX, then fleet_x += STEP_X.
  - Otherwise drop: fleet_y += DROP_Y, dir becomes LEFT, x is unchanged.
- Moving LEFT: mirror of RIGHT using fleet_x-STEP_X >= X_MIN. Compare before subtracting, so there is no underflow.
- Landing: if a drop would make fleet_y >= LAND_Y, do not drop. Instead:
  - Pulse player_collision for one clk.
  - Reset fleet_x, fleet_y and dir to their start values.
  - Keep the alive mask.
- Wave clear: when alive becomes 6'b0, go to RESPAWN on the next clk and set frame_cnt to 0.
- RESPAWN:
  - Count frame pulses.
  - On the RESPAWN_FRAMES-th pulse, set alive=6'b111111, fleet_x=X_START, fleet_y=Y_START, dir=RIGHT, frame_cnt=0, and go to PLAY.
  - No hits and no movement happen in RESPAWN.
- Simultaneous hit and move tick on one clk:
  - The hit is judged on the pre-move position.
  - Both updates commit on the same edge.
- A hit that kills the last invader on a move-tick clk still moves; the fleet enters RESPAWN on the next clk.
- arst: on a clk edge with arst=1, every register returns to its reset value.
- rst: asynchronously forces every register to its reset value, overriding everything.
- Reset values:
  - invaders_x=X_START, invaders_y=Y_START.
  - invader_alive=6'b111111.
  - invader_collision=0, player_collision=0.
  - dir=RIGHT, frame_cnt=0, state=PLAY.

## Timing
- All outputs are registered.
- Hit to invader_collision: 1 clk after laser_active and the in-box coordinates are sampled.
- Frame pulse to position update: visible 1 clk after the qualifying frame pulse.
- Landing to player_collision: asserted 1 clk after the qualifying frame pulse, for exactly 1 clk.
- The laser must not rely on invader_collision beyond one clk; score_logic counts pulses.
- laser_x and laser_y are assumed stable for at least 1 clk while laser_active is high.

## Test plan
- Reset and march:
  - Stimulus: rst pulse, then 4 frame pulses.
  - Response: reset shows x=64, y=48, alive=111111, pulses=0. After the 4th frame x=68 and y=48.
- Right edge:
  - Stimulus: march until x=280, then one more tick.
  - Response: y=64, x=280, dir=LEFT. The next tick gives x=276.
- Hit:
  - Stimulus: laser_active=1 at (x=64+128+5, y=50).
  - Response: invader_collision=6'b000100 for exactly 1 clk; alive=111011. The laser held in place produces no second pulse.
- Simultaneous hit and move tick:
  - Stimulus: the same clk as the hit carries the qualifying frame pulse.
  - Response: the hit is registered, x advances by 4, and both are visible on the same cycle.
- Wave clear and respawn:
  - Stimulus: hit all 6 invaders, then 60 frame pulses.
  - Response: state is RESPAWN, a laser in any box gives no pulse, and after the 60th frame alive=111111 at (64,48).
- Landing and arst:
  - Stimulus: force fleet_y=432 and drive a drop tick; separately, assert arst mid-march.
  - Response: player_collision pulses for 1 clk and the position returns to (64,48). arst restores all reset values on the next edge.
